// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction ROM address/data, hazard and redirect
// controls coming back from decode/execute, and the IF/ID outputs with
// the debug counters.
interface instr_fetch_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0] imem_rdata;
    logic             stall;
    logic             redirect;
    logic [WIDTH-1:0] redirect_base;
    logic [WIDTH-1:0] redirect_offset;
    logic [WIDTH-1:0] if_instr;
    logic [WIDTH-1:0] if_pc;
    logic             if_valid;
    logic [CNT_W-1:0] fetch_count;
    logic [CNT_W-1:0] redirect_count;

    // The fetch stage itself.
    modport master (
        output imem_addr,
        input  imem_rdata,
        input  stall,
        input  redirect,
        input  redirect_base,
        input  redirect_offset,
        output if_instr,
        output if_pc,
        output if_valid,
        output fetch_count,
        output redirect_count
    );

    // The surrounding pipeline and ROM.
    modport slave (
        input  imem_addr,
        output imem_rdata,
        output stall,
        output redirect,
        output redirect_base,
        output redirect_offset,
        input  if_instr,
        input  if_pc,
        input  if_valid,
        input  fetch_count,
        input  redirect_count
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage of the 16-bit three-stage pipeline: owns the PC, addresses
// the combinational instruction ROM, fills the IF/ID register, applies
// branch/jump redirects and hazard stalls, and keeps saturating debug
// counters for fetches and redirects.
module instr_fetch #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = 16'h0000,
    parameter logic [WIDTH-1:0] NOP      = 16'h0000,
    parameter int               CNT_W    = 16
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);

    logic [WIDTH-1:0] pc_q,       pc_d;
    logic [WIDTH-1:0] instr_q,    instr_d;
    logic [WIDTH-1:0] ifpc_q,     ifpc_d;
    logic             valid_q,    valid_d;
    logic [CNT_W-1:0] fcnt_q,     fcnt_d;
    logic [CNT_W-1:0] rcnt_q,     rcnt_d;

    // The ROM address is the PC register itself, so stall and redirect
    // never reach imem_addr combinationally.
    assign bus.imem_addr      = pc_q;
    assign bus.if_instr       = instr_q;
    assign bus.if_pc          = ifpc_q;
    assign bus.if_valid       = valid_q;
    assign bus.fetch_count    = fcnt_q;
    assign bus.redirect_count = rcnt_q;

    // Next-state selection with priority redirect > stall > normal fetch;
    // a redirect flushes IF/ID, so a coincident stall is irrelevant.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        valid_d = valid_q;
        fcnt_d  = fcnt_q;
        rcnt_d  = rcnt_q;
        if (bus.redirect) begin
            pc_d    = bus.redirect_base + bus.redirect_offset;
            instr_d = NOP;
            valid_d = 1'b0;
            if (rcnt_q != '1) begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end else if (!bus.stall) begin
            pc_d    = pc_q + 1'b1;
            instr_d = bus.imem_rdata;
            ifpc_d  = pc_q;
            valid_d = 1'b1;
            if (fcnt_q != '1) begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // PC, IF/ID register and counters, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            ifpc_q  <= '0;
            valid_q <= 1'b0;
            fcnt_q  <= '0;
            rcnt_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            valid_q <= valid_d;
            fcnt_q  <= fcnt_d;
            rcnt_q  <= rcnt_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a table of fetch/stall/redirect
// vectors checked through an expected-value queue on the default
// instance, plus hand-written sequences for PC wrap, counter saturation
// (narrow-counter instance) and asynchronous reset.
module tb_instr_fetch;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [15:0] base;
        logic [15:0] offset;
        logic [15:0] instr;
        logic [15:0] pc;
        logic        valid;
        logic [15:0] addr;
        logic [15:0] fc;
        logic [15:0] rc;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    vec_t vecs[14];
    vec_t exp_q[$];

    instr_fetch_if #(.WIDTH(16), .CNT_W(16)) bus_a ();
    instr_fetch_if #(.WIDTH(16), .CNT_W(2))  bus_b ();

    instr_fetch #(
        .WIDTH(16), .RESET_PC(16'h0000), .NOP(16'h0000), .CNT_W(16)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    instr_fetch #(
        .WIDTH(16), .RESET_PC(16'hFFFE), .NOP(16'h0000), .CNT_W(2)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    // Instruction ROM model: ROM[i] = 16'h1000 + i.
    assign bus_a.imem_rdata = 16'h1000 + bus_a.imem_addr;
    assign bus_b.imem_rdata = 16'h1000 + bus_b.imem_addr;

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic r,
                                 input logic [15:0] b, input logic [15:0] o);
        bus_a.stall           = s;
        bus_a.redirect        = r;
        bus_a.redirect_base   = b;
        bus_a.redirect_offset = o;
    endtask

    task automatic checkA(input string tag, input logic [15:0] instr,
                          input logic [15:0] pc, input logic valid,
                          input logic [15:0] addr, input logic [15:0] fc,
                          input logic [15:0] rc);
        checkOutput({tag, "_instr"}, {16'h0, bus_a.if_instr}, {16'h0, instr});
        checkOutput({tag, "_pc"},    {16'h0, bus_a.if_pc},    {16'h0, pc});
        checkOutput({tag, "_valid"}, {31'h0, bus_a.if_valid}, {31'h0, valid});
        checkOutput({tag, "_addr"},  {16'h0, bus_a.imem_addr}, {16'h0, addr});
        checkOutput({tag, "_fc"},    {16'h0, bus_a.fetch_count},    {16'h0, fc});
        checkOutput({tag, "_rc"},    {16'h0, bus_a.redirect_count}, {16'h0, rc});
    endtask

    task automatic checkB(input string tag, input logic [15:0] instr,
                          input logic [15:0] pc, input logic valid,
                          input logic [15:0] addr, input logic [1:0] fc,
                          input logic [1:0] rc);
        checkOutput({tag, "_instr"}, {16'h0, bus_b.if_instr}, {16'h0, instr});
        checkOutput({tag, "_pc"},    {16'h0, bus_b.if_pc},    {16'h0, pc});
        checkOutput({tag, "_valid"}, {31'h0, bus_b.if_valid}, {31'h0, valid});
        checkOutput({tag, "_addr"},  {16'h0, bus_b.imem_addr}, {16'h0, addr});
        checkOutput({tag, "_fc"},    {30'h0, bus_b.fetch_count},    {30'h0, fc});
        checkOutput({tag, "_rc"},    {30'h0, bus_b.redirect_count}, {30'h0, rc});
    endtask

    initial begin
        vec_t        got;
        logic [15:0] prev_addr;
        logic [15:0] b_instr[5];
        logic [15:0] b_pc[5];
        logic [15:0] b_addr[5];
        logic [1:0]  b_fc[5];

        checks = 0;
        errors = 0;

        //            stall redir base     offset   instr    pc       v     addr     fc  rc
        vecs[0]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1000, 16'h0000, 1'b1, 16'h0001, 16'd1, 16'd0};
        vecs[1]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1001, 16'h0001, 1'b1, 16'h0002, 16'd2, 16'd0};
        vecs[2]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1001, 16'h0001, 1'b1, 16'h0002, 16'd2, 16'd0};
        vecs[3]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1001, 16'h0001, 1'b1, 16'h0002, 16'd2, 16'd0};
        vecs[4]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1001, 16'h0001, 1'b1, 16'h0002, 16'd2, 16'd0};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1002, 16'h0002, 1'b1, 16'h0003, 16'd3, 16'd0};
        vecs[6]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1003, 16'h0003, 1'b1, 16'h0004, 16'd4, 16'd0};
        vecs[7]  = '{1'b0, 1'b1, 16'h0010, 16'hFFFB, 16'h0000, 16'h0003, 1'b0, 16'h000B, 16'd4, 16'd1};
        vecs[8]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h100B, 16'h000B, 1'b1, 16'h000C, 16'd5, 16'd1};
        vecs[9]  = '{1'b1, 1'b1, 16'h0004, 16'h0006, 16'h0000, 16'h000B, 1'b0, 16'h000A, 16'd5, 16'd2};
        vecs[10] = '{1'b0, 1'b1, 16'h0030, 16'h0005, 16'h0000, 16'h000B, 1'b0, 16'h0035, 16'd5, 16'd3};
        vecs[11] = '{1'b0, 1'b1, 16'h0100, 16'hFF34, 16'h0000, 16'h000B, 1'b0, 16'h0034, 16'd5, 16'd4};
        vecs[12] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1034, 16'h0034, 1'b1, 16'h0035, 16'd6, 16'd4};
        vecs[13] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1034, 16'h0034, 1'b1, 16'h0035, 16'd6, 16'd4};

        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        bus_b.stall           = 1'b1;
        bus_b.redirect        = 1'b0;
        bus_b.redirect_base   = 16'h0000;
        bus_b.redirect_offset = 16'h0000;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkA("rst_a", 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'd0, 16'd0);
        checkB("rst_b", 16'h0000, 16'h0000, 1'b0, 16'hFFFE, 2'd0, 2'd0);

        // Table vectors on the default instance, checked through the queue.
        prev_addr = 16'h0000;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].stall, vecs[i].redirect, vecs[i].base, vecs[i].offset);
            exp_q.push_back(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d_addr_pre", i), {16'h0, bus_a.imem_addr},
                        {16'h0, prev_addr});
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checkOutput($sformatf("v%0d_queue", i), 32'd0, 32'd1);
            end else begin
                got = exp_q.pop_front();
                checkA($sformatf("v%0d", i), got.instr, got.pc, got.valid,
                       got.addr, got.fc, got.rc);
                prev_addr = got.addr;
            end
            @(negedge clk);
        end
        applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000);

        // PC wrap from 16'hFFFE and fetch-counter saturation on the 2-bit instance.
        b_instr = '{16'h0FFE, 16'h0FFF, 16'h1000, 16'h1001, 16'h1002};
        b_pc    = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002};
        b_addr  = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003};
        b_fc    = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        bus_b.stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkB($sformatf("wrap%0d", i), b_instr[i], b_pc[i], 1'b1,
                   b_addr[i], b_fc[i], 2'd0);
            @(negedge clk);
        end

        // Redirect-counter saturation on the 2-bit instance.
        bus_b.redirect        = 1'b1;
        bus_b.redirect_base   = 16'h0020;
        bus_b.redirect_offset = 16'h0003;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checkB($sformatf("rsat%0d", i), 16'h0000, 16'h0002, 1'b0, 16'h0023,
                   2'd3, (i < 3) ? 2'(i + 1) : 2'd3);
            @(negedge clk);
        end
        bus_b.redirect = 1'b0;
        bus_b.stall    = 1'b1;

        // Asynchronous reset mid-cycle while pc=0x35 and if_valid=1, with
        // redirect and stall also asserted.
        checkA("pre_arst", 16'h1034, 16'h0034, 1'b1, 16'h0035, 16'd6, 16'd4);
        applyStimulus(1'b1, 1'b1, 16'h0040, 16'h0001);
        #2;
        reset = 1'b1;
        #1;
        checkA("arst", 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'd0, 16'd0);
        @(posedge clk);
        #1;
        checkA("arst_hold", 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'd0, 16'd0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkA("post_rst", 16'h1000, 16'h0000, 1'b1, 16'h0001, 16'd1, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Fetch stage of the 16-bit three-stage pipeline. It sits directly upstream of decode/immediate generation. It owns the PC and drives the word address to the external combinational instruction ROM. It captures the returned word into the IF/ID register that feeds the immediate generator and register-file decode. It applies branch/jump redirects (base + sign-extended immediate from the execute stage) and hazard stalls, and keeps saturating fetch and redirect counters for debug.

Parameters:
WIDTH, 16, datapath, PC and instruction width in bits
RESET_PC, 16'h0000, PC value loaded on reset (word address)
NOP, 16'h0000, bubble instruction inserted into IF/ID on reset and on flush
CNT_W, 16, width of the debug counters

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
imem_addr  output  WIDTH  word address to instruction ROM; combinational copy of the PC register
imem_rdata  input  WIDTH  instruction word from ROM, valid in the same cycle as imem_addr
stall  input  1  hazard stall from decode/execute; freezes PC and IF/ID
redirect  input  1  taken branch or jump from execute
redirect_base  input  WIDTH  PC of the redirecting instruction
redirect_offset  input  WIDTH  sign-extended immediate from the immediate generator
if_instr  output  WIDTH  IF/ID instruction register
if_pc  output  WIDTH  PC of the instruction in if_instr
if_valid  output  1  if_instr is a real fetched instruction (0 means bubble)
fetch_count  output  CNT_W  number of instructions captured, saturating
redirect_count  output  CNT_W  number of redirects taken, saturating

Behaviour:
- Clock and reset: single clock `clk`. Reset is asynchronous and active-high (`reset`).
- Registered state: pc, if_instr, if_pc, if_valid, fetch_count, redirect_count. No other state.
- While reset is asserted, asynchronously: pc=RESET_PC, if_instr=NOP, if_pc=0, if_valid=0, both counters=0. imem_addr=RESET_PC.
- Reset asserted mid-operation takes effect immediately, regardless of stall or redirect.
- imem_addr = pc at all times. There is no combinational path from stall or redirect to imem_addr.
- Per rising edge with reset low, priority is redirect > stall > normal.
- Normal (redirect=0, stall=0):
  - if_instr<=imem_rdata, if_pc<=pc, if_valid<=1.
  - pc<=pc+1 modulo 2^WIDTH, so 16'hFFFF wraps to 16'h0000.
  - fetch_count increments unless it is all-ones.
- Stall (redirect=0, stall=1): pc, if_instr, if_pc, if_valid and both counters hold.
- Redirect (redirect=1, any stall):
  - pc<=(redirect_base+redirect_offset) truncated to WIDTH. Two's-complement wrap; no overflow flag.
  - if_instr<=NOP, if_valid<=0, if_pc holds.
  - redirect_count increments unless it is all-ones. fetch_count holds.
  - A stall coincident with a redirect is overridden, because the flushed IF/ID content is discarded anyway.
- Redirects on consecutive cycles are each applied. The last one wins for pc.
- Latency:
  - The instruction at RESET_PC appears on if_instr/if_valid after the first rising edge with reset low.
  - After a redirect edge, the target instruction appears one further edge later. This is a one-cycle bubble, with if_valid low for exactly one cycle if stall stays low.
- Counter saturation: at all-ones, a counter stays at all-ones. It never wraps.

Test Plan:
- Reset then 4 unstalled cycles, ROM[i]=16'h1000+i -> if_instr sequence 1000,1001,1002,1003. if_pc 0,1,2,3. if_valid=1 from the first edge. fetch_count=4. imem_addr=4.
- Stall high for 3 cycles at pc=2 -> imem_addr stays 2. if_instr/if_pc/if_valid/fetch_count unchanged. On release, the fetch resumes with ROM[2].
- Redirect with base=16'h0010, offset=16'hFFFB -> the next edge gives if_valid=0, if_instr=NOP, pc=16'h000B, redirect_count=1. The edge after gives if_instr=ROM[0x0B], if_pc=16'h000B.
- Redirect and stall asserted together, base=16'h0004, offset=16'h0006 -> pc=16'h000A, if_valid=0. Redirect wins.
- Start with RESET_PC=16'hFFFE, 3 normal cycles -> if_pc FFFE, FFFF, 0000. Then imem_addr=16'h0001.
- Assert reset asynchronously mid-cycle while pc=16'h0035 and if_valid=1 -> before the next clock edge: pc/imem_addr=RESET_PC, if_valid=0, if_instr=NOP, counters 0.
